id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection, directly upstream of the EX-stage forwarding/operand-select logic.
- Captures decoded operands and control from ID each cycle.
- Inserts bubbles on load-use hazards and branch redirects.
- Holds its contents on an external stall.
- Produces every *_E operand and control signal that the EX forwarding mux consumes.

Parameters:
XLEN, 32, datapath width (PC, register data, immediate)
CNT_W, 32, width of bubble performance counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
valid_D  input  1  ID holds a real instruction
PC_reg_D  input  XLEN  PC of ID instruction
rdata1_D  input  XLEN  register file read port 1
rdata2_D  input  XLEN  register file read port 2
imme_D  input  XLEN  decoded immediate
Rs1_D  input  5  source register 1
Rs2_D  input  5  source register 2
Rd_D  input  5  destination register
RegWrite_D  input  1  instruction writes Rd
MemRead_D  input  1  instruction is a load
reg_ren_D  input  1  instruction reads Rs1
rs2_used_D  input  1  instruction reads Rs2 (R-type, store, branch)
auipc_D  input  1  ALU A-operand is PC
ALU_DB_Src_D  input  1  ALU B-operand from register (1) or immediate (0)
flush_E  input  1  branch/jump redirect resolved in EX; kill ID instruction
stall_ext  input  1  downstream/memory stall; freeze this register
RegWrite_W  input  1  WB write enable (bypass feature only)
Rd_W  input  5  WB destination (bypass feature only)
rdata_reg_W  input  XLEN  WB write data (bypass feature only)
valid_E, PC_reg_E, rdata1_E, rdata2_E, imme_E, Rs1_E, Rs2_E, Rd_E, RegWrite_E, MemRead_E, reg_ren_E, auipc_E, ALU_DB_Src_E  output  (same widths as *_D)  registered EX-stage copies
stall_D  output  1  hold PC and IF/ID register this cycle (combinational)
bubble_cnt  output  CNT_W  count of load-use bubbles inserted

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all registered state is sampled on the rising edge of clk.
- Reset: all *_E outputs are 0 and bubble_cnt is 0. While rst is high, stall_D = 0.
- Bubble: all *_E fields, including Rs1_E, Rs2_E and Rd_E, become 0. Zero register indices guarantee the downstream forwarding logic never matches.
- Load-use hazard (combinational), lu is true when all of these hold:
  - valid_E & MemRead_E & RegWrite_E & (Rd_E != 0)
  - and either (reg_ren_D & Rs1_D == Rd_E) or (rs2_used_D & Rs2_D == Rd_E)
- stall_D = (lu & ~flush_E) | stall_ext.
- Next-state priority, highest first:
  1. rst: clear.
  2. flush_E: load bubble. A coincident lu is ignored and stall_D is not asserted for lu.
  3. stall_ext: hold all *_E unchanged. lu is still reflected in stall_D, and no bubble is counted.
  4. lu: load bubble. bubble_cnt increments, saturating at all-ones.
  5. Otherwise: capture *_D into *_E. valid_E = valid_D; if valid_D = 0, all control bits are captured as 0.
- Latency: one cycle D to E. Exactly one bubble per load-use, because after the bubble MemRead_E = 0 and lu drops.
- Back-to-back: a load followed by a dependent load stalls once per dependency. Each lu-induced bubble increments bubble_cnt by 1.
- Reset mid-stall: the stall is abandoned, the register clears, and bubble_cnt returns to 0.
- No combinational path from *_D inputs to *_E outputs. stall_D is combinational from *_D inputs and registered *_E state.

Optional Feature:
ID_WB_BYPASS_EN. Applies on capture (priority 5) only.
- Defined:
  - If RegWrite_W & Rd_W != 0 & Rd_W == Rs1_D, rdata1_E captures rdata_reg_W instead of rdata1_D.
  - Same rule for Rs2_D and rdata2_E.
  - This covers register files without write-before-read.
- Undefined:
  - rdata*_E always capture rdata*_D.
  - RegWrite_W, Rd_W and rdata_reg_W are unused. The ports remain present so the interface is unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles with nonzero inputs -> all *_E = 0, bubble_cnt = 0, stall_D = 0.
- Plain capture: valid_D=1, PC_reg_D=0x100, Rs1_D=3, rdata1_D=0xDEAD, RegWrite_D=1 -> next cycle PC_reg_E=0x100, Rs1_E=3, rdata1_E=0xDEAD, valid_E=1.
- Load-use: E holds a load (MemRead_E=1, Rd_E=5); ID has Rs2_D=5, rs2_used_D=1 -> stall_D=1 that cycle; next cycle all *_E = 0 and bubble_cnt = 1; following cycle ID instruction captured, stall_D=0.
- Flush beats hazard: same load-use setup plus flush_E=1 -> stall_D=0, bubble inserted, bubble_cnt unchanged.
- External stall: stall_ext=1 for 3 cycles with changing *_D -> *_E frozen, stall_D=1; on release the current *_D is captured.
- Bypass (ID_WB_BYPASS_EN): RegWrite_W=1, Rd_W=7, rdata_reg_W=0x1234, Rs1_D=7, rdata1_D=0 -> rdata1_E=0x1234. Same stimulus without the macro -> rdata1_E=0. With Rd_W=0 -> rdata1_E=0 in both builds.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional ID_WB_BYPASS_EN: forward the WB write data into rdata*_E on capture.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_D,
    input  logic [XLEN-1:0]   PC_reg_D,
    input  logic [XLEN-1:0]   rdata1_D,
    input  logic [XLEN-1:0]   rdata2_D,
    input  logic [XLEN-1:0]   imme_D,
    input  logic [4:0]        Rs1_D,
    input  logic [4:0]        Rs2_D,
    input  logic [4:0]        Rd_D,
    input  logic              RegWrite_D,
    input  logic              MemRead_D,
    input  logic              reg_ren_D,
    input  logic              rs2_used_D,
    input  logic              auipc_D,
    input  logic              ALU_DB_Src_D,
    input  logic              flush_E,
    input  logic              stall_ext,
    input  logic              RegWrite_W,
    input  logic [4:0]        Rd_W,
    input  logic [XLEN-1:0]   rdata_reg_W,
    output logic              valid_E,
    output logic [XLEN-1:0]   PC_reg_E,
    output logic [XLEN-1:0]   rdata1_E,
    output logic [XLEN-1:0]   rdata2_E,
    output logic [XLEN-1:0]   imme_E,
    output logic [4:0]        Rs1_E,
    output logic [4:0]        Rs2_E,
    output logic [4:0]        Rd_E,
    output logic              RegWrite_E,
    output logic              MemRead_E,
    output logic              reg_ren_E,
    output logic              auipc_E,
    output logic              ALU_DB_Src_E,
    output logic              stall_D,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic            w_hit1;
    logic            w_hit2;
    logic            w_lu;
    logic            w_clear;
    logic            w_bubble_lu;
    logic [XLEN-1:0] w_rdata1_nxt;
    logic [XLEN-1:0] w_rdata2_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_hit1 = reg_ren_D  && (Rs1_D == Rd_E);
    assign w_hit2 = rs2_used_D && (Rs2_D == Rd_E);
    assign w_lu   = valid_E && MemRead_E && RegWrite_E && (Rd_E != 5'd0) && (w_hit1 || w_hit2);

    assign stall_D = !rst && ((w_lu && !flush_E) || stall_ext);

    // A lu bubble only happens when neither a redirect nor an external freeze outranks it.
    assign w_bubble_lu = w_lu && !flush_E && !stall_ext;
    assign w_clear     = rst || flush_E || w_bubble_lu;

`ifdef ID_WB_BYPASS_EN
    assign w_rdata1_nxt = (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs1_D)) ? rdata_reg_W : rdata1_D;
    assign w_rdata2_nxt = (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs2_D)) ? rdata_reg_W : rdata2_D;
`else
    logic w_unused_wb;
    assign w_unused_wb  = ^{RegWrite_W, Rd_W, rdata_reg_W};
    assign w_rdata1_nxt = rdata1_D;
    assign w_rdata2_nxt = rdata2_D;
`endif

    always_ff @(posedge clk) begin
        if (w_clear) begin
            valid_E      <= 1'b0;
            PC_reg_E     <= '0;
            rdata1_E     <= '0;
            rdata2_E     <= '0;
            imme_E       <= '0;
            Rs1_E        <= '0;
            Rs2_E        <= '0;
            Rd_E         <= '0;
            RegWrite_E   <= 1'b0;
            MemRead_E    <= 1'b0;
            reg_ren_E    <= 1'b0;
            auipc_E      <= 1'b0;
            ALU_DB_Src_E <= 1'b0;
        end else if (!stall_ext) begin
            valid_E      <= valid_D;
            PC_reg_E     <= PC_reg_D;
            rdata1_E     <= w_rdata1_nxt;
            rdata2_E     <= w_rdata2_nxt;
            imme_E       <= imme_D;
            Rs1_E        <= Rs1_D;
            Rs2_E        <= Rs2_D;
            Rd_E         <= Rd_D;
            RegWrite_E   <= valid_D && RegWrite_D;
            MemRead_E    <= valid_D && MemRead_D;
            reg_ren_E    <= valid_D && reg_ren_D;
            auipc_E      <= valid_D && auipc_D;
            ALU_DB_Src_E <= valid_D && ALU_DB_Src_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (w_bubble_lu) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand sequences for stall/reset corners.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_D = 1'b0;
    logic [31:0] PC_reg_D = '0, rdata1_D = '0, rdata2_D = '0, imme_D = '0;
    logic [4:0]  Rs1_D = '0, Rs2_D = '0, Rd_D = '0;
    logic        RegWrite_D = 1'b0, MemRead_D = 1'b0, reg_ren_D = 1'b0, rs2_used_D = 1'b0;
    logic        auipc_D = 1'b0, ALU_DB_Src_D = 1'b0, flush_E = 1'b0, stall_ext = 1'b0;
    logic        RegWrite_W = 1'b0;
    logic [4:0]  Rd_W = '0;
    logic [31:0] rdata_reg_W = '0;

    logic        valid_E, RegWrite_E, MemRead_E, reg_ren_E, auipc_E, ALU_DB_Src_E, stall_D;
    logic [31:0] PC_reg_E, rdata1_E, rdata2_E, imme_E, bubble_cnt;
    logic [4:0]  Rs1_E, Rs2_E, Rd_E;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .valid_D(valid_D), .PC_reg_D(PC_reg_D),
        .rdata1_D(rdata1_D), .rdata2_D(rdata2_D), .imme_D(imme_D),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D), .RegWrite_D(RegWrite_D),
        .MemRead_D(MemRead_D), .reg_ren_D(reg_ren_D), .rs2_used_D(rs2_used_D),
        .auipc_D(auipc_D), .ALU_DB_Src_D(ALU_DB_Src_D), .flush_E(flush_E),
        .stall_ext(stall_ext), .RegWrite_W(RegWrite_W), .Rd_W(Rd_W),
        .rdata_reg_W(rdata_reg_W), .valid_E(valid_E), .PC_reg_E(PC_reg_E),
        .rdata1_E(rdata1_E), .rdata2_E(rdata2_E), .imme_E(imme_E),
        .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E), .RegWrite_E(RegWrite_E),
        .MemRead_E(MemRead_E), .reg_ren_E(reg_ren_E), .auipc_E(auipc_E),
        .ALU_DB_Src_E(ALU_DB_Src_E), .stall_D(stall_D), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic        rst, vld, fl, sx, mr, rw, ren, r2u;
        logic [31:0] pc, rd1;
        logic [4:0]  rs1, rs2, rd;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        es, bub, ev, emr, erw;
        logic [31:0] epc, erd1, ecnt;
        logic [4:0]  ers1, erd;
    } vec_t;

    localparam logic [31:0] BYP1 =
`ifdef ID_WB_BYPASS_EN
        32'h1234;
`else
        32'h0;
`endif

    function automatic vec_t V(
        input logic rst, vld, fl, sx, mr, rw, ren, r2u,
        input logic [31:0] pc, rd1, input logic [4:0] rs1, rs2, rd,
        input logic es, bub, ev, emr, erw,
        input logic [31:0] epc, erd1, input logic [4:0] ers1, erd, input logic [31:0] ecnt);
        vec_t v;
        v.rst = rst; v.vld = vld; v.fl = fl; v.sx = sx; v.mr = mr; v.rw = rw;
        v.ren = ren; v.r2u = r2u; v.pc = pc; v.rd1 = rd1; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.wrw = 1'b0; v.wrd = '0; v.wdat = '0;
        v.es = es; v.bub = bub; v.ev = ev; v.emr = emr; v.erw = erw;
        v.epc = epc; v.erd1 = erd1; v.ers1 = ers1; v.erd = erd; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic any_out;
        @(negedge clk);
        rst = v.rst; valid_D = v.vld; flush_E = v.fl; stall_ext = v.sx;
        MemRead_D = v.mr; RegWrite_D = v.rw; reg_ren_D = v.ren; rs2_used_D = v.r2u;
        PC_reg_D = v.pc; rdata1_D = v.rd1; rdata2_D = v.pc ^ 32'h5A5A_0000; imme_D = v.pc + 32'd4;
        Rs1_D = v.rs1; Rs2_D = v.rs2; Rd_D = v.rd; auipc_D = v.rw; ALU_DB_Src_D = v.ren;
        RegWrite_W = v.wrw; Rd_W = v.wrd; rdata_reg_W = v.wdat;
        #1;
        chk($sformatf("%s stall_D", tag), {31'b0, stall_D}, {31'b0, v.es});
        @(posedge clk);
        #1;
        if (v.bub) begin
            any_out = |{valid_E, PC_reg_E, rdata1_E, rdata2_E, imme_E, Rs1_E, Rs2_E, Rd_E,
                        RegWrite_E, MemRead_E, reg_ren_E, auipc_E, ALU_DB_Src_E};
            chk($sformatf("%s all_E_zero", tag), {31'b0, any_out}, 32'd0);
        end else begin
            chk($sformatf("%s valid_E", tag), {31'b0, valid_E}, {31'b0, v.ev});
            chk($sformatf("%s PC_reg_E", tag), PC_reg_E, v.epc);
            chk($sformatf("%s rdata1_E", tag), rdata1_E, v.erd1);
            chk($sformatf("%s Rs1_E", tag), {27'b0, Rs1_E}, {27'b0, v.ers1});
            chk($sformatf("%s Rd_E", tag), {27'b0, Rd_E}, {27'b0, v.erd});
            chk($sformatf("%s MemRead_E", tag), {31'b0, MemRead_E}, {31'b0, v.emr});
            chk($sformatf("%s RegWrite_E", tag), {31'b0, RegWrite_E}, {31'b0, v.erw});
        end
        chk($sformatf("%s bubble_cnt", tag), bubble_cnt, v.ecnt);
    endtask

    vec_t tbl[17];
    vec_t s;

    initial begin
        //            rst vld fl sx mr rw ren r2u  pc        rd1         rs1 rs2 rd   es bub ev emr erw epc       erd1        ers1 erd cnt
        tbl[0]  = V(1, 1, 0, 0, 1, 1, 1, 0, 32'h55,  32'h77,   5, 5, 5,   0, 1, 0, 0, 0, 32'h0,   32'h0,     0, 0,  0);
        tbl[1]  = tbl[0];
        tbl[2]  = V(0, 1, 0, 0, 0, 1, 1, 0, 32'h100, 32'hDEAD, 3, 0, 0,   0, 0, 1, 0, 1, 32'h100, 32'hDEAD,  3, 0,  0);
        tbl[3]  = V(0, 1, 0, 0, 1, 1, 1, 0, 32'h104, 32'h11,   3, 0, 5,   0, 0, 1, 1, 1, 32'h104, 32'h11,    3, 5,  0);
        tbl[4]  = V(0, 1, 0, 0, 0, 1, 1, 1, 32'h108, 32'h33,   1, 5, 6,   1, 1, 0, 0, 0, 32'h0,   32'h0,     0, 0,  1);
        tbl[5]  = V(0, 1, 0, 0, 0, 1, 1, 1, 32'h108, 32'h33,   1, 5, 6,   0, 0, 1, 0, 1, 32'h108, 32'h33,    1, 6,  1);
        tbl[6]  = V(0, 1, 0, 0, 1, 1, 0, 0, 32'h10C, 32'h44,   0, 0, 7,   0, 0, 1, 1, 1, 32'h10C, 32'h44,    0, 7,  1);
        tbl[7]  = V(0, 1, 1, 0, 0, 1, 1, 0, 32'h110, 32'h55,   7, 0, 8,   0, 1, 0, 0, 0, 32'h0,   32'h0,     0, 0,  1);
        tbl[8]  = V(0, 0, 0, 0, 1, 1, 1, 0, 32'h114, 32'h66,   2, 0, 9,   0, 0, 0, 0, 0, 32'h114, 32'h66,    2, 9,  1);
        tbl[9]  = V(0, 1, 0, 0, 1, 1, 0, 0, 32'h118, 32'h77,   0, 0, 4,   0, 0, 1, 1, 1, 32'h118, 32'h77,    0, 4,  1);
        tbl[10] = V(0, 1, 0, 0, 1, 1, 1, 0, 32'h11C, 32'h88,   4, 0, 10,  1, 1, 0, 0, 0, 32'h0,   32'h0,     0, 0,  2);
        tbl[11] = V(0, 1, 0, 0, 1, 1, 1, 0, 32'h11C, 32'h88,   4, 0, 10,  0, 0, 1, 1, 1, 32'h11C, 32'h88,    4, 10, 2);
        tbl[12] = V(0, 1, 0, 0, 0, 1, 0, 0, 32'h120, 32'h99,   10, 10, 11, 0, 0, 1, 0, 1, 32'h120, 32'h99,   10, 11, 2);
        tbl[13] = V(0, 1, 0, 0, 1, 1, 0, 0, 32'h124, 32'hAA,   0, 0, 0,   0, 0, 1, 1, 1, 32'h124, 32'hAA,    0, 0,  2);
        tbl[14] = V(0, 1, 0, 0, 0, 1, 1, 1, 32'h128, 32'hBB,   0, 0, 3,   0, 0, 1, 0, 1, 32'h128, 32'hBB,    0, 3,  2);
        tbl[15] = V(0, 1, 0, 0, 0, 1, 1, 0, 32'h12C, 32'h0,    7, 0, 12,  0, 0, 1, 0, 1, 32'h12C, BYP1,      7, 12, 2);
        tbl[15].wrw = 1'b1; tbl[15].wrd = 5'd7; tbl[15].wdat = 32'h1234;
        tbl[16] = V(0, 1, 0, 0, 0, 1, 1, 0, 32'h130, 32'h0,    0, 0, 13,  0, 0, 1, 0, 1, 32'h130, 32'h0,     0, 13, 2);
        tbl[16].wrw = 1'b1; tbl[16].wrd = 5'd0; tbl[16].wdat = 32'h1234;

        for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // External stall: E frozen for three cycles while ID changes underneath.
        for (int k = 0; k < 3; k++) begin
            s = V(0, 1, 0, 1, 0, 1, 1, 0, 32'h200 + 32'(4 * k), 32'hC0 + 32'(k), 1, 2, 14,
                  1, 0, 1, 0, 1, 32'h130, 32'h0, 0, 13, 2);
            apply(s, $sformatf("xstall%0d", k));
        end
        s = V(0, 1, 0, 0, 0, 1, 1, 0, 32'h20C, 32'hCC, 1, 2, 14, 0, 0, 1, 0, 1, 32'h20C, 32'hCC, 1, 14, 2);
        apply(s, "xstall_release");

        // External stall coincident with a load-use: hold, no count; bubble after release.
        s = V(0, 1, 0, 0, 1, 1, 0, 0, 32'h210, 32'hD0, 0, 0, 12, 0, 0, 1, 1, 1, 32'h210, 32'hD0, 0, 12, 2);
        apply(s, "lu_load");
        s = V(0, 1, 0, 1, 0, 1, 1, 0, 32'h214, 32'hD4, 12, 0, 15, 1, 0, 1, 1, 1, 32'h210, 32'hD0, 0, 12, 2);
        apply(s, "lu_xstall");
        s = V(0, 1, 0, 0, 0, 1, 1, 0, 32'h214, 32'hD4, 12, 0, 15, 1, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 3);
        apply(s, "lu_bubble");
        s = V(0, 1, 0, 0, 0, 1, 1, 0, 32'h214, 32'hD4, 12, 0, 15, 0, 0, 1, 0, 1, 32'h214, 32'hD4, 12, 15, 3);
        apply(s, "lu_capture");

        // Reset arriving while a load-use stall is pending.
        s = V(0, 1, 0, 0, 1, 1, 0, 0, 32'h218, 32'hD8, 0, 0, 13, 0, 0, 1, 1, 1, 32'h218, 32'hD8, 0, 13, 3);
        apply(s, "rst_load");
        s = V(0, 1, 0, 1, 0, 1, 1, 0, 32'h21C, 32'hDC, 13, 0, 16, 1, 0, 1, 1, 1, 32'h218, 32'hD8, 0, 13, 3);
        apply(s, "rst_pending");
        s = V(1, 1, 0, 1, 0, 1, 1, 0, 32'h21C, 32'hDC, 13, 0, 16, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        apply(s, "rst_mid_stall");
        s = V(0, 1, 0, 0, 0, 1, 1, 0, 32'h21C, 32'hDC, 13, 0, 16, 0, 0, 1, 0, 1, 32'h21C, 32'hDC, 13, 16, 0);
        apply(s, "rst_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
